// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for bcd_down_timer: preset and run controls in, BCD count and status out.
// The controller drives through the master modport; the timer sees the slave view.
interface bcd_down_timer_if #(
   parameter int DIGITS = 2
);
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  start;
   logic                  pause;
   logic                  tick;
   logic [4*DIGITS-1:0]   count;
   logic                  busy;
   logic                  done;
   logic                  zero;

   modport master (
      output load, load_val, start, pause, tick,
      input  count, busy, done, zero
   );

   modport slave (
      input  load, load_val, start, pause, tick,
      output count, busy, done, zero
   );
endinterface

// File: rtl/bcd_down_timer.sv
// Preset BCD down-counter: one decrement per tick in RUN, registered done pulse on reaching zero.
// Count and done are registered; no backpressure, load and pause act on the next clk edge.
module bcd_down_timer #(
   parameter int DIGITS = 2
) (
   input  logic            clk,
   input  logic            reset,
   bcd_down_timer_if.slave bus
);
   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_DONE} state_t;

   state_t         state_q, state_nxt;
   logic [W-1:0]   count_q, count_nxt;
   logic           done_q;

   // Out-of-range digits clamp to 9 independently of their neighbours.
   function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   // Full borrow chain resolved combinationally, e.g. 100 -> 099 in one cycle.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         count_q <= count_nxt;
         done_q  <= (state_nxt == ST_DONE);
      end
   end

   always_comb begin
      state_nxt = state_q;
      count_nxt = count_q;
      if (bus.load) begin
         count_nxt = bcd_sanitize(bus.load_val);
         state_nxt = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) state_nxt = (count_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
               if (bus.pause) begin
                  state_nxt = ST_HOLD;
               end else if (bus.tick) begin
                  count_nxt = bcd_dec(count_q);
                  if (count_q == W'(1)) state_nxt = ST_DONE;
               end
            end
            ST_HOLD: begin
               if (!bus.pause) state_nxt = ST_RUN;
            end
            ST_DONE: begin
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.count = count_q;
      bus.busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
      bus.done  = done_q;
      bus.zero  = (count_q == '0);
   end
endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Multi-digit BCD down-counter/timer; the count-down counterpart to the team's decade up-counter.
- Loads a BCD preset, then decrements once per qualified tick until it reaches zero.
- Signals completion with a one-cycle done pulse.
- Used as a countdown/timeout block alongside the up-counters in the counter library.

Parameters:
- DIGITS, 2, number of BCD digits (count width = 4*DIGITS); legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- load  input  1  synchronous preset strobe.
- load_val  input  4*DIGITS  BCD preset value; digit [3:0] is least significant.
- start  input  1  begin countdown from IDLE.
- pause  input  1  level; freeze countdown while high.
- tick  input  1  decrement qualifier; one decrement per clk edge with tick=1 in RUN.
- count  output  4*DIGITS  current BCD value (registered).
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle completion pulse (registered).
- zero  output  1  count == 0 (combinational from count register).

Behaviour:
- Reset: reset=0 asynchronously forces count=0, state=IDLE, done=0. Outputs are therefore busy=0, zero=1.
  - Assertion mid-RUN/HOLD aborts the countdown immediately.
  - Release takes effect at the next clk edge.
- Priority at each edge: reset > load > state-machine actions (pause > tick).
- Load: load=1 sets count <= sanitized load_val, state <= IDLE, done <= 0, from any state.
  - Sanitizing: any digit with value >9 is clamped to 9 per digit; other digits are unaffected.
- States: IDLE, RUN, HOLD, DONE. done=1 only on the cycle the FSM is in DONE.
- IDLE:
  - start=1 with count!=0 -> RUN.
  - start=1 with count==0 -> DONE.
  - Otherwise remain in IDLE; count holds.
- RUN:
  - pause=1 -> HOLD; count holds even if tick=1.
  - Else if tick=1: count decrements by 1 in BCD.
    - Digit 0 becomes 9 and borrows into the next digit.
    - A digit that is not 0 decrements and stops the borrow.
  - If count==1 and it is decremented, count becomes 0 and state -> DONE. done is high on the following cycle, concurrent with count==0.
  - tick=0 holds count. start is ignored.
- HOLD: count frozen. pause=0 -> RUN; the next decrement happens no earlier than the following edge with tick=1.
- DONE: done=1, count=0. Unconditionally -> IDLE at the next edge, so done is exactly one cycle wide.
  - start while in DONE is ignored.
- No wrap-around: count never decrements below 0. RUN is never entered with count==0.
- Multi-digit borrow is resolved in a single cycle, e.g. 100 -> 099 with DIGITS=3.
- Latency: start -> first decrement at the first tick edge after entering RUN. With continuous ticks, preset N gives done N+1 cycles after the start edge.

Test Plan:
- DIGITS=2. reset=0 while count=37 in RUN -> count=00, busy=0, zero=1, done=0 immediately, without a clk edge.
- load_val=8'h25, load, start, tick held 1 -> count steps 25,24,...,20,19,...,01,00. done high exactly one cycle, with count=00. Then IDLE, busy=0.
- load_val=8'h10, start, tick pulsed every 3rd cycle -> count 10 -> 09 on the first tick (borrow). Count changes only on tick cycles.
- Preset 08, RUN, assert pause for 5 cycles with tick=1 -> count frozen at its current value, state HOLD, busy=1. On release, decrements resume on the next tick edge.
- load_val=8'hAF -> count=99 (both digits clamped). load_val=00, start -> done pulse one cycle later; count stays 00; busy never asserts.
- load asserted mid-RUN with load_val=8'h42 -> count=42, state IDLE, busy=0, no done pulse.
- Simultaneous load and start -> load wins and state is IDLE. A second start then begins the countdown.
